// File: rtl/bram_window_pkg.sv
// Shared defaults, FSM state type and window sizing helper for the BRAM window reader.
package bram_window_pkg;

  localparam int DEF_IMG_W  = 64;
  localparam int DEF_IMG_H  = 128;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;

  // Pixels in a 3x3 neighbourhood and width of the raster coordinate outputs
  localparam int WIN_PIX = 9;
  localparam int COORD_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  // Bit width of a packed 3x3 window of pixels that are dataW bits wide
  function automatic int win_bits(input int dataW);
    return WIN_PIX * dataW;
  endfunction

endpackage

// File: rtl/bram_window_reader_line_buffer.sv
// Fixed-latency pixel delay line: a pixel shifted in reappears on dout_o
// exactly DEPTH shifts later. Contents are never cleared; the reader masks
// stale data with its own validity gating.
module line_buffer
  import bram_window_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_DATA_W
) (
  input  logic             clk_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [DEPTH-1:0][WIDTH-1:0] taps_q;

  // Move every stored pixel one tap further along the line on each absorb
  always_ff @(posedge clk_i) begin
    if (shift_i) begin
      taps_q <= {taps_q[DEPTH-2:0], din_i};
    end
  end

  assign dout_o = taps_q[DEPTH-1];

endmodule

// File: rtl/bram_window_reader.sv
// Streams a stored greyscale frame out of the pixel BRAM in raster order and
// presents one registered 3x3 neighbourhood per absorbed pixel to the edge stage.
module bram_window_reader
  import bram_window_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                        clka,
  input  logic                        rsta,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        bram_en,
  output logic                        bram_we,
  output logic [ADDR_W-1:0]           bram_addr,
  input  logic [DATA_W-1:0]           bram_dout,
  output logic                        win_valid,
  output logic [win_bits(DATA_W)-1:0] win,
  output logic [COORD_W-1:0]          win_x,
  output logic [COORD_W-1:0]          win_y
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] LAST_Y    = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] FIRST_WIN = COORD_W'(2);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]                addr_q;
  logic                             rdValid_q;
  logic [COORD_W-1:0]               xPos_q;
  logic [COORD_W-1:0]               yPos_q;
  logic [WIN_PIX-1:0][DATA_W-1:0]   win_q;
  logic                             winValid_q;
  logic [COORD_W-1:0]               winX_q;
  logic [COORD_W-1:0]               winY_q;

  logic              frameStart;
  logic [DATA_W-1:0] lb0Out;
  logic [DATA_W-1:0] lb1Out;

  // A frame may begin from IDLE or directly out of the DONE cycle
  assign frameStart = start && ((state_q == IDLE) || (state_q == DONE));

  // FSM state register
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: DRAIN waits until the read pipeline no longer holds a pixel
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   if (!rdValid_q) state_d = DONE;
      DONE:    state_d = start ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: BRAM is only enabled while addresses are being issued
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    bram_en = 1'b0;
    case (state_q)
      READ: begin
        busy    = 1'b1;
        bram_en = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Address issue path: one address per READ cycle, restarting at 0 on each frame
  always_ff @(posedge clka) begin
    if (rsta) begin
      addr_q    <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= bram_en;
      if (frameStart) begin
        addr_q <= '0;
      end else if (state_q == READ) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Absorb path: raster counters track the pixel arriving on bram_dout, and the
  // window shifts left with each new column taken from the BRAM and line buffers
  always_ff @(posedge clka) begin
    if (rsta) begin
      xPos_q     <= '0;
      yPos_q     <= '0;
      win_q      <= '0;
      winValid_q <= 1'b0;
      winX_q     <= '0;
      winY_q     <= '0;
    end else begin
      winValid_q <= 1'b0;
      if (frameStart) begin
        xPos_q <= '0;
        yPos_q <= '0;
      end else if (rdValid_q) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb1Out;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb0Out;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= bram_dout;
        if ((xPos_q >= FIRST_WIN) && (yPos_q >= FIRST_WIN)) begin
          winValid_q <= 1'b1;
          winX_q     <= xPos_q - 1'b1;
          winY_q     <= yPos_q - 1'b1;
        end
        if (xPos_q == LAST_X) begin
          xPos_q <= '0;
          yPos_q <= (yPos_q == LAST_Y) ? '0 : yPos_q + 1'b1;
        end else begin
          xPos_q <= xPos_q + 1'b1;
        end
      end
    end
  end

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) u_lineBuf0 (
    .clk_i   (clka),
    .shift_i (rdValid_q),
    .din_i   (bram_dout),
    .dout_o  (lb0Out)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) u_lineBuf1 (
    .clk_i   (clka),
    .shift_i (rdValid_q),
    .din_i   (lb0Out),
    .dout_o  (lb1Out)
  );

  assign bram_we   = 1'b0;
  assign bram_addr = addr_q;
  assign win_valid = winValid_q;
  assign win       = win_q;
  assign win_x     = winX_q;
  assign win_y     = winY_q;

endmodule

// File: tb/tb_bram_window_reader.sv
// Self-checking bench for bram_window_reader: behavioural BRAM, frame-level
// window model derived from raster arithmetic, directed frame sequence.
module tb_bram_window_reader;

  localparam int W      = 64;
  localparam int H      = 128;
  localparam int N      = W * H;
  localparam int NWIN   = (W - 2) * (H - 2);
  localparam int DONE_T = N + 2;
  // Pixel k is addressed in cycle k, returned in k+1 and shown as a window in k+2
  localparam int FIRST_T = (2 * W + 2) + 2;

  logic         clka = 1'b0;
  logic         rsta;
  logic         start;
  logic         busy;
  logic         done;
  logic         bramEn;
  logic         bramWe;
  logic [12:0]  bramAddr;
  logic [7:0]   bramDout;
  logic         winValid;
  logic [71:0]  win;
  logic [6:0]   winX;
  logic [6:0]   winY;

  logic [7:0]   mem [0:N-1];

  int           checkCount = 0;
  int           passCount  = 0;
  int           winCount;
  int           doneCount;
  int           firstValidT;
  int           lastX;
  int           lastY;
  logic [71:0]  firstWin;

  localparam logic [71:0] RAMP_FIRST_WIN =
    {8'd130, 8'd129, 8'd128, 8'd66, 8'd65, 8'd64, 8'd2, 8'd1, 8'd0};

  bram_window_reader dut (
    .clka      (clka),
    .rsta      (rsta),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bram_en   (bramEn),
    .bram_we   (bramWe),
    .bram_addr (bramAddr),
    .bram_dout (bramDout),
    .win_valid (winValid),
    .win       (win),
    .win_x     (winX),
    .win_y     (winY)
  );

  // 100 MHz-style free-running clock
  always #5 clka = ~clka;

  // Single-port BRAM with one cycle of read latency
  always @(posedge clka) begin
    if (bramEn) bramDout <= mem[bramAddr];
  end

  // One comparison: counts it, and reports tag/observed/expected on failure
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic loadRamp();
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
  endtask

  task automatic loadRandom();
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
  endtask

  // The 3x3 neighbourhood whose bottom-right pixel is raster index k
  function automatic logic [71:0] expWindow(input int k);
    int x = k % W;
    int y = k / W;
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = mem[(y - 2 + r) * W + (x - 2 + c)];
    return w;
  endfunction

  // All outputs together; must be zero while in or just out of reset
  task automatic checkResetState(input string tag);
    checkOutput(tag, 128'({busy, done, bramEn, bramWe, bramAddr, winValid, win, winX, winY}), 128'(0));
  endtask

  task automatic checkIdle(input int n);
    repeat (n) begin
      @(negedge clka);
      checkOutput("idle", 128'({busy, done, bramEn, bramWe, winValid}), 128'(0));
    end
  endtask

  // Compare every output in cycle t of a frame (t=0 is the first READ cycle)
  task automatic checkCycle(input int t);
    int k = t - 2;
    bit expEn = (t < N);
    bit expValid = (k >= 0) && (k < N) && ((k % W) >= 2) && ((k / W) >= 2);
    checkOutput("bram_en", 128'(bramEn), 128'(expEn));
    checkOutput("bram_we", 128'(bramWe), 128'(0));
    if (expEn) checkOutput("bram_addr", 128'(bramAddr), 128'(t));
    checkOutput("busy", 128'(busy), 128'(t <= N + 1));
    checkOutput("done", 128'(done), 128'(t == DONE_T));
    checkOutput("win_valid", 128'(winValid), 128'(expValid));
    if (done === 1'b1) doneCount++;
    if (winValid === 1'b1) begin
      winCount++;
      if (winCount == 1) begin
        firstValidT = t;
        firstWin    = win;
      end
      lastX = int'(winX);
      lastY = int'(winY);
    end
    if (expValid) begin
      checkOutput("win", 128'(win), 128'(expWindow(k)));
      checkOutput("win_x", 128'(winX), 128'((k % W) - 1));
      checkOutput("win_y", 128'(winY), 128'((k / W) - 1));
    end
  endtask

  // Request a frame and follow it to its done cycle (or to cycle abortAt)
  task automatic applyStimulus(input bit holdStart, input int abortAt);
    winCount    = 0;
    doneCount   = 0;
    firstValidT = -1;
    lastX       = -1;
    lastY       = -1;
    firstWin    = '0;
    start = 1'b1;
    @(negedge clka);
    if (!holdStart) start = 1'b0;
    for (int t = 0; t <= DONE_T; t++) begin
      checkCycle(t);
      if (t == abortAt) break;
      if (t != DONE_T) @(negedge clka);
    end
  endtask

  task automatic checkFrame(input bit isRamp);
    checkOutput("win_count", 128'(winCount), 128'(NWIN));
    checkOutput("first_valid_cycle", 128'(firstValidT), 128'(FIRST_T));
    checkOutput("last_win_x", 128'(lastX), 128'(W - 2));
    checkOutput("last_win_y", 128'(lastY), 128'(H - 2));
    checkOutput("done_pulses", 128'(doneCount), 128'(1));
    if (isRamp) checkOutput("ramp_first_win", 128'(firstWin), 128'(RAMP_FIRST_WIN));
  endtask

  initial begin
    rsta  = 1'b1;
    start = 1'b0;
    loadRamp();
    repeat (3) begin
      @(negedge clka);
      checkResetState("reset_state");
    end
    rsta = 1'b0;
    @(negedge clka);
    checkResetState("post_reset_idle");

    // Ramp frame from idle
    applyStimulus(1'b0, -1);
    checkFrame(1'b1);
    checkIdle($urandom_range(1, 4));

    // Random frame with start held high, then a back-to-back random frame
    loadRandom();
    applyStimulus(1'b1, -1);
    checkFrame(1'b0);
    loadRandom();
    applyStimulus(1'b0, -1);
    checkFrame(1'b0);
    checkIdle(2);

    // Abort mid-frame at address 3000, then a clean ramp frame
    loadRamp();
    applyStimulus(1'b0, 3000);
    rsta = 1'b1;
    repeat (3) begin
      @(negedge clka);
      checkResetState("abort_reset");
    end
    rsta = 1'b0;
    @(negedge clka);
    checkResetState("abort_idle");
    applyStimulus(1'b0, -1);
    checkFrame(1'b1);
    checkIdle(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
